ball_motion: RTL and testbench

Ball kinematics and round controller for the Pong datapath, the producer side of the ball/bat collision checker. It owns `ball_x`/`ball_y`, which the collision checker reads, and consumes the checker's `dir_x`, `dir_y`, `collision` and `outofbounds` outputs. On every frame tick it advances the ball, runs the serve/play/score sequence, keeps both scores, and ramps ball speed with rally length.

---
 rtl/ball_motion_if.sv | 28 ++
 rtl/ball_motion.sv | 203 ++++++++++++++++++++
 tb/tb_ball_motion.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// Signal bundle between the ball kinematics block and its environment:
// frame strobe and collision-checker feedback in, ball state and score out.
interface ball_motion_if;
  logic        tick;
  logic        dir_x;
  logic        dir_y;
  logic        collision;
  logic        outofbounds;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic        round_reset;
  logic [3:0]  p1_score;
  logic [3:0]  p2_score;
  logic        game_over;
  logic [3:0]  speed;

  // Environment side: drives strobe and checker feedback, observes the ball.
  modport master (
    output tick, dir_x, dir_y, collision, outofbounds,
    input  ball_x, ball_y, round_reset, p1_score, p2_score, game_over, speed
  );

  // Ball block side.
  modport slave (
    input  tick, dir_x, dir_y, collision, outofbounds,
    output ball_x, ball_y, round_reset, p1_score, p2_score, game_over, speed
  );
endinterface

// File: rtl/ball_motion.sv
// Ball kinematics and round controller for the Pong datapath.
// Moves the ball on each frame tick, sequences serve/play/score, keeps both
// scores and raises ball speed as rallies get longer.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   S_SERVE   | ball held at centre, counting ticks before play
//   S_PLAY    | ball moves on tick; collisions ramp the speed
//   S_SCORED  | single cycle booking the point for the latched player
//   S_OVER    | winning score reached; frozen until reset
module ball_motion #(
  parameter int HC               = 1280,
  parameter int VC               = 480,
  parameter int BALLSIZE         = 16,
  parameter int INIT_SPEED       = 2,
  parameter int MAX_SPEED        = 8,
  parameter int HITS_PER_SPEEDUP = 8,
  parameter int SERVE_TICKS      = 60,
  parameter int WIN_SCORE        = 7
) (
  input  logic         clk,
  input  logic         reset,
  ball_motion_if.slave bus
);

  typedef enum logic [1:0] {
    S_SERVE  = 2'd0,
    S_PLAY   = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [11:0] X_LIM_W   = 12'(HC);
  localparam logic [11:0] Y_LIM_W   = 12'(VC - BALLSIZE);
  localparam logic [10:0] X_LIM     = 11'(HC);
  localparam logic [10:0] Y_LIM     = 11'(VC - BALLSIZE);
  localparam logic [10:0] CENTRE_X  = 11'((HC - BALLSIZE) / 2);
  localparam logic [10:0] CENTRE_Y  = 11'((VC - BALLSIZE) / 2);
  localparam logic [10:0] HALF_X    = 11'(HC / 2);
  localparam logic [3:0]  SPD_INIT  = 4'(INIT_SPEED);
  localparam logic [3:0]  SPD_MAX   = 4'(MAX_SPEED);
  localparam logic [3:0]  HIT_LAST  = 4'(HITS_PER_SPEEDUP - 1);
  localparam logic [6:0]  SERVE_LAST = 7'(SERVE_TICKS - 1);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [3:0]  p1_q, p1_d;
  logic [3:0]  p2_q, p2_d;
  logic [3:0]  speed_q, speed_d;
  logic [6:0]  serve_q, serve_d;
  logic [3:0]  hit_q, hit_d;
  logic        scorer_p2_q, scorer_p2_d;
  logic        round_reset_q, round_reset_d;
  logic        coll_q;

  logic [11:0] x_ext, y_ext, sp_ext;
  logic [11:0] x_sum, x_dif, y_sum, y_dif;
  logic [10:0] x_move, y_move;
  logic        hit_edge;
  logic [3:0]  score_inc;

  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign sp_ext = {8'd0, speed_q};
  assign x_sum  = x_ext + sp_ext;
  assign x_dif  = x_ext - sp_ext;
  assign y_sum  = y_ext + sp_ext;
  assign y_dif  = y_ext - sp_ext;

  assign hit_edge  = bus.collision & ~coll_q;
  assign score_inc = (scorer_p2_q ? p2_q : p1_q) + 4'd1;

  // Candidate next position for a tick in play, clamped to the playfield.
  // The right edge clamps at HC itself so the checker can see the miss.
  always_comb begin
    x_move = x_q;
    y_move = y_q;
    if (bus.dir_x) begin
      x_move = (x_sum > X_LIM_W) ? X_LIM : x_sum[10:0];
    end else begin
      x_move = (x_ext < sp_ext) ? 11'd0 : x_dif[10:0];
    end
    if (bus.dir_y) begin
      y_move = (y_sum > Y_LIM_W) ? Y_LIM : y_sum[10:0];
    end else begin
      y_move = (y_ext < sp_ext) ? 11'd0 : y_dif[10:0];
    end
  end

  // Round sequencing: next state, position, scores, speed ramp.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    speed_d       = speed_q;
    serve_d       = serve_q;
    hit_d         = hit_q;
    scorer_p2_d   = scorer_p2_q;
    round_reset_d = 1'b0;

    case (state_q)
      S_SERVE: begin
        x_d = CENTRE_X;
        y_d = CENTRE_Y;
        if (bus.tick) begin
          if (serve_q == SERVE_LAST) begin
            serve_d = '0;
            state_d = S_PLAY;
          end else begin
            serve_d = serve_q + 7'd1;
          end
        end
      end

      S_PLAY: begin
        // A collision held high for several cycles is one hit.
        if (hit_edge) begin
          if (hit_q == HIT_LAST) begin
            hit_d = '0;
            if (speed_q < SPD_MAX) speed_d = speed_q + 4'd1;
          end else begin
            hit_d = hit_q + 4'd1;
          end
        end
        // A miss freezes the ball where it is, even if a tick coincides.
        if (bus.outofbounds) begin
          state_d     = S_SCORED;
          scorer_p2_d = (x_q < HALF_X);
        end else if (bus.tick) begin
          x_d = x_move;
          y_d = y_move;
        end
      end

      S_SCORED: begin
        if (scorer_p2_q) p2_d = score_inc;
        else             p1_d = score_inc;
        x_d = CENTRE_X;
        y_d = CENTRE_Y;
        if (score_inc == WIN) begin
          state_d = S_OVER;
        end else begin
          state_d       = S_SERVE;
          speed_d       = SPD_INIT;
          hit_d         = '0;
          serve_d       = '0;
          round_reset_d = 1'b1;
        end
      end

      S_OVER: begin
        x_d = CENTRE_X;
        y_d = CENTRE_Y;
      end

      default: begin
        state_d = S_SERVE;
      end
    endcase
  end

  // State and datapath registers; reset overrides every pending action.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SERVE;
      x_q           <= CENTRE_X;
      y_q           <= CENTRE_Y;
      p1_q          <= '0;
      p2_q          <= '0;
      speed_q       <= SPD_INIT;
      serve_q       <= '0;
      hit_q         <= '0;
      scorer_p2_q   <= 1'b0;
      round_reset_q <= 1'b0;
      coll_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      speed_q       <= speed_d;
      serve_q       <= serve_d;
      hit_q         <= hit_d;
      scorer_p2_q   <= scorer_p2_d;
      round_reset_q <= round_reset_d;
      coll_q        <= bus.collision;
    end
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.round_reset = round_reset_q;
  assign bus.p1_score    = p1_q;
  assign bus.p2_score    = p2_q;
  assign bus.game_over   = (state_q == S_OVER);
  assign bus.speed       = speed_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: stimulus pushes hand-computed expected
// outputs into a queue, a monitor pops and compares them on the falling edge.
module tb_ball_motion;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ball_motion_if bif();

  ball_motion dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    string       name;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic [3:0]  spd;
    logic        rr;
    logic        go;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // One clock: apply inputs, wait for the edge, settle past it.
  task automatic cyc(input logic t, input logic oob = 1'b0,
                     input logic col = 1'b0, input logic rst = 1'b0);
    reset           = rst;
    bif.tick        = t;
    bif.outofbounds = oob;
    bif.collision   = col;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1);
  endtask

  // Each pulse: collision high for three cycles, then one low cycle.
  task automatic coll_pulses(input int n);
    repeat (n) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic expect_out(input string n, input int x, input int y,
                            input int p1, input int p2, input int spd,
                            input logic rr, input logic go);
    exp_t e;
    e.name = n;
    e.x    = 11'(x);
    e.y    = 11'(y);
    e.p1   = 4'(p1);
    e.p2   = 4'(p2);
    e.spd  = 4'(spd);
    e.rr   = rr;
    e.go   = go;
    sb.push_back(e);
  endtask

  // A P1 point: serve, move right to x=640 (first x credited to P1), miss.
  task automatic p1_round(input int p1_after);
    bif.dir_x = 1'b1;
    bif.dir_y = 1'b1;
    ticks(60);
    expect_out("r_serve_hold", 632, 232, p1_after - 1, 1, 2, 1'b0, 1'b0);
    ticks(4);
    expect_out("r_at_half", 640, 240, p1_after - 1, 1, 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    expect_out("r_scored", 640, 240, p1_after - 1, 1, 2, 1'b0, 1'b0);
    cyc(1'b0);
    expect_out("r_point_p1", 632, 232, p1_after, 1, 2, 1'b1, 1'b0);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bif.ball_x !== e.x || bif.ball_y !== e.y ||
            bif.p1_score !== e.p1 || bif.p2_score !== e.p2 ||
            bif.speed !== e.spd || bif.round_reset !== e.rr ||
            bif.game_over !== e.go) begin
          errors++;
          $display("FAIL %s: got x=%0d y=%0d p1=%0d p2=%0d spd=%0d rr=%0b go=%0b, want x=%0d y=%0d p1=%0d p2=%0d spd=%0d rr=%0b go=%0b",
                   e.name, bif.ball_x, bif.ball_y, bif.p1_score, bif.p2_score,
                   bif.speed, bif.round_reset, bif.game_over,
                   e.x, e.y, e.p1, e.p2, e.spd, e.rr, e.go);
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bif.tick        = 1'b0;
    bif.dir_x       = 1'b1;
    bif.dir_y       = 1'b1;
    bif.collision   = 1'b0;
    bif.outofbounds = 1'b0;

    // Reset and first serve.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("reset_vals", 632, 232, 0, 0, 2, 1'b0, 1'b0);
    ticks(59);
    expect_out("serve_59", 632, 232, 0, 0, 2, 1'b0, 1'b0);
    ticks(1);
    expect_out("serve_60_no_move", 632, 232, 0, 0, 2, 1'b0, 1'b0);
    ticks(1);
    expect_out("play_tick1", 634, 234, 0, 0, 2, 1'b0, 1'b0);
    ticks(2);
    expect_out("play_tick3", 638, 238, 0, 0, 2, 1'b0, 1'b0);

    // Bottom clamp.
    ticks(112);
    expect_out("y_462", 862, 462, 0, 0, 2, 1'b0, 1'b0);
    ticks(1);
    expect_out("y_464", 864, 464, 0, 0, 2, 1'b0, 1'b0);
    ticks(1);
    expect_out("y_clamp_hold", 866, 464, 0, 0, 2, 1'b0, 1'b0);

    // Speed-up boundary: 7 hits no change, 8th hit steps speed.
    coll_pulses(7);
    expect_out("hits_7", 866, 464, 0, 0, 2, 1'b0, 1'b0);
    coll_pulses(1);
    expect_out("hits_8_speedup", 866, 464, 0, 0, 3, 1'b0, 1'b0);

    // Move up-left at speed 3: top clamp, then left clamp.
    bif.dir_x = 1'b0;
    bif.dir_y = 1'b0;
    ticks(154);
    expect_out("up_y2", 404, 2, 0, 0, 3, 1'b0, 1'b0);
    ticks(1);
    expect_out("up_clamp0", 401, 0, 0, 0, 3, 1'b0, 1'b0);
    ticks(133);
    expect_out("left_x2", 2, 0, 0, 0, 3, 1'b0, 1'b0);
    ticks(1);
    expect_out("left_clamp0", 0, 0, 0, 0, 3, 1'b0, 1'b0);
    ticks(1);
    expect_out("left_hold0", 0, 0, 0, 0, 3, 1'b0, 1'b0);

    // Miss on the left with a coincident tick: P2 scores.
    cyc(1'b1, 1'b1);
    expect_out("oob_no_move", 0, 0, 0, 0, 3, 1'b0, 1'b0);
    cyc(1'b0);
    expect_out("p2_point", 632, 232, 0, 1, 2, 1'b1, 1'b0);
    cyc(1'b0);
    expect_out("rr_one_cycle", 632, 232, 0, 1, 2, 1'b0, 1'b0);

    // Round 2: collisions in SERVE ignored, then speed saturation.
    coll_pulses(8);
    expect_out("serve_coll_ignored", 632, 232, 0, 1, 2, 1'b0, 1'b0);
    bif.dir_x = 1'b1;
    bif.dir_y = 1'b1;
    ticks(60);
    expect_out("r2_play", 632, 232, 0, 1, 2, 1'b0, 1'b0);
    coll_pulses(48);
    expect_out("hits_48", 632, 232, 0, 1, 8, 1'b0, 1'b0);
    coll_pulses(8);
    expect_out("speed_saturated", 632, 232, 0, 1, 8, 1'b0, 1'b0);
    ticks(81);
    expect_out("right_edge", 1280, 464, 0, 1, 8, 1'b0, 1'b0);
    ticks(1);
    expect_out("right_clamp", 1280, 464, 0, 1, 8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    expect_out("r2_scored", 1280, 464, 0, 1, 8, 1'b0, 1'b0);
    cyc(1'b0);
    expect_out("p1_point1", 632, 232, 1, 1, 2, 1'b1, 1'b0);

    // P1 to 6.
    for (int k = 2; k <= 6; k++) p1_round(k);

    // Winning miss at the right edge.
    bif.dir_x = 1'b1;
    bif.dir_y = 1'b1;
    ticks(60);
    ticks(324);
    expect_out("r8_edge", 1280, 464, 6, 1, 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    expect_out("r8_scored", 1280, 464, 6, 1, 2, 1'b0, 1'b0);
    cyc(1'b0);
    expect_out("game_over", 632, 232, 7, 1, 2, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    ticks(70);
    coll_pulses(9);
    expect_out("over_frozen", 632, 232, 7, 1, 2, 1'b0, 1'b1);

    // Reset leaves OVER; then reset coinciding with a miss mid-play.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("reset_from_over", 632, 232, 0, 0, 2, 1'b0, 1'b0);
    ticks(60);
    ticks(3);
    expect_out("r9_moving", 638, 238, 0, 0, 2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out("reset_wins_oob", 632, 232, 0, 0, 2, 1'b0, 1'b0);
    cyc(1'b0);
    expect_out("post_reset_quiet", 632, 232, 0, 0, 2, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
